split_target: RTL and testbench
===============================

Name: split_target

Overview:
- Bus-side responder (target) for the serial bus; the counterpart of the bus initiator.
- Accepts address and data beats from the bus and writes them into a local byte memory.
- Returns read data either while holding the bus or through a split transaction: it issues a split acknowledge, releases the bus, then re-requests it when the data is ready.
- Sits behind the address decoder; it sees only transactions routed to it.

Parameters:
- MEM_ADDR_WIDTH, 8, local memory index width; depth is 2**MEM_ADDR_WIDTH bytes.
- READ_LATENCY, 4, cycles from read-address capture to data available; legal range 1..15.
- SPLIT_ENABLE, 1'b1: 1 = every read is split; 0 = reads hold the bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- target_addr_in  in  16  bus address; only bits [MEM_ADDR_WIDTH-1:0] are used.
- target_addr_in_valid  in  1  one-cycle address strobe.
- target_data_in  in  8  write data.
- target_data_in_valid  in  1  one-cycle write-data strobe.
- target_rw  in  1  1 = write, 0 = read; sampled with target_addr_in_valid or target_data_in_valid.
- target_split_grant  in  1  arbiter grant for a split-return bus request.
- target_ready  out  1  high only in S_IDLE.
- target_ack  out  1  one-cycle transaction-complete pulse.
- target_split_ack  out  1  one-cycle pulse: read accepted as split, bus released.
- target_split_req  out  1  bus request to return split read data.
- target_data_out  out  8  read data.
- target_data_out_valid  out  1  one-cycle read-data strobe.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state S_IDLE; target_ready 1; target_ack, target_split_ack, target_split_req and target_data_out_valid all 0; target_data_out 8'h00; latency counter 0.
- Memory: initialised to 8'h00 at time zero. Reset does not clear it.
- All outputs are registered.

State machine:
- S_IDLE:
  - addr_valid with rw=1: latch address. If data_valid is also high, latch data and go to S_WRITE; otherwise go to S_WR_WAIT_DATA.
  - data_valid alone with rw=1: latch data, go to S_WR_WAIT_ADDR.
  - addr_valid with rw=0: latch address, load counter = READ_LATENCY-1.
    - SPLIT_ENABLE=1: pulse target_split_ack on the next cycle, go to S_RD_SPLIT_WAIT.
    - SPLIT_ENABLE=0: go to S_RD_WAIT.
  - data_valid with rw=0: ignored.
- S_WR_WAIT_DATA / S_WR_WAIT_ADDR: wait indefinitely for the missing strobe, latch it, go to S_WRITE. A repeated strobe of the already-captured kind overwrites the latched value.
- S_WRITE: write mem[addr], pulse target_ack for 1 cycle, return to S_IDLE.
  - Write latency: ack is registered 1 cycle after the later of the two strobes.
- S_RD_WAIT: decrement the counter each cycle. At 0, present mem[addr] on target_data_out with target_data_out_valid=1 and target_ack=1 for exactly 1 cycle, then go to S_IDLE.
  - Valid rises READ_LATENCY+1 cycles after the address strobe.
- S_RD_SPLIT_WAIT: decrement the counter. At 0, assert target_split_req and go to S_RD_SPLIT_REQ.
- S_RD_SPLIT_REQ: hold target_split_req until target_split_grant is sampled high.
  - Next cycle: drop target_split_req and drive target_data_out_valid=1 with target_ack=1 for 1 cycle (data and ack coincide), then go to S_IDLE.
  - If grant is already high the same cycle req rises, it is honoured on the following cycle.

Boundary conditions:
- Strobes arriving while target_ready=0 (other than those listed above) are ignored with no side effect.
- Read data is sampled from memory at the counter-zero edge, so a read returns the latest prior write.
- target_data_out retains its last value after valid drops.
- Reset mid-transaction: immediate return to S_IDLE; split_req and all pulses drop; latched address/data are discarded; memory keeps its contents.
- Counter width is 4 bits. READ_LATENCY=1 means the counter loads 0, giving valid 2 cycles after the address strobe (S_RD_WAIT).
- Upper address bits are ignored: 16'h1234 with MEM_ADDR_WIDTH=8 selects index 8'h34.

Test Plan:
- Write, same-cycle strobes: addr 16'h0012, data 8'hAA, rw=1, both valid in one cycle -> target_ack pulses 1 cycle later; target_ready low for 1 cycle.
- Write, split strobes: data 8'h5C, then 3 idle cycles, then addr 16'h0034 -> ack 1 cycle after the address strobe; a later read of 16'h0034 returns 8'h5C.
- Non-split read (SPLIT_ENABLE=0, READ_LATENCY=4): read 16'h0012 after the first test -> data_out 8'hAA with valid=ack=1 exactly 5 cycles after the strobe; no split_ack.
- Split read (SPLIT_ENABLE=1): read 16'h0012 -> split_ack 1 cycle after the strobe; split_req rises 4 cycles after the strobe; hold grant low 6 cycles, then high -> next cycle data 8'hAA with valid and ack; split_req low.
- Busy rejection: during a split wait, inject write addr 16'h0099, data 8'h11 -> no ack; mem[8'h99] stays 8'h00.
- Reset in S_RD_SPLIT_REQ: deassert rst_n mid-request -> split_req=0 asynchronously, ready=1; a subsequent read of 16'h0012 still returns 8'hAA.

Source files
------------

// File: rtl/split_target.sv
// split_target: bus-side responder with a local byte memory.
//
// Writes arrive as an address beat and a data beat, in the same cycle or in
// either order. Reads either hold the bus until the data is ready or, when
// SPLIT_ENABLE is set, release it with a split acknowledge and re-request it
// once the data is available.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   target_addr_in[_valid]   address beat; only the low MEM_ADDR_WIDTH bits index memory
//   target_data_in[_valid]   write data beat
//   target_rw                1 = write, 0 = read; qualified by either strobe
//   target_split_grant       arbiter grant for the split-return request
//   target_ready             high only while idle
//   target_ack               one-cycle completion pulse (writes and reads)
//   target_split_ack         one-cycle pulse: read accepted as split, bus released
//   target_split_req         request for the bus to return split read data
//   target_data_out[_valid]  read data and its one-cycle strobe; data holds afterwards
module split_target #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned READ_LATENCY   = 4,
    parameter bit          SPLIT_ENABLE   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        target_rw,
    input  logic        target_split_grant,
    output logic        target_ready,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        target_split_req,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid
);

    localparam int unsigned MemDepth = 2 ** MEM_ADDR_WIDTH;
    localparam logic [3:0]  CntLoad  = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrWaitData,
        StWrWaitAddr,
        StWrite,
        StRdWait,
        StRdSplitWait,
        StRdSplitReq
    } state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      ready_q, ready_d;
    logic                      ack_q, ack_d;
    logic                      split_ack_q, split_ack_d;
    logic                      split_req_q, split_req_d;
    logic                      dvalid_q, dvalid_d;
    logic [7:0]                dout_q, dout_d;

    // Memory contents survive reset; only power-up clears them.
    logic [7:0]                mem_q [MemDepth] = '{default: 8'h00};
    logic                      mem_we;
    logic [7:0]                mem_rdata;

    logic [MEM_ADDR_WIDTH-1:0] addr_idx;
    logic                      addr_stb;
    logic                      data_stb;

    assign addr_idx  = target_addr_in[MEM_ADDR_WIDTH-1:0];
    assign addr_stb  = target_addr_in_valid;
    assign data_stb  = target_data_in_valid;
    assign mem_rdata = mem_q[addr_q];

    // Upper address bits are decoded upstream and deliberately ignored here.
    if (MEM_ADDR_WIDTH < 16) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^target_addr_in[15:MEM_ADDR_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        split_ack_d = 1'b0;
        split_req_d = split_req_q;
        dvalid_d    = 1'b0;
        dout_d      = dout_q;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (addr_stb && target_rw) begin
                    addr_d = addr_idx;
                    if (data_stb) begin
                        wdata_d = target_data_in;
                        ack_d   = 1'b1;
                        state_d = StWrite;
                    end else begin
                        state_d = StWrWaitData;
                    end
                end else if (data_stb && target_rw) begin
                    wdata_d = target_data_in;
                    state_d = StWrWaitAddr;
                end else if (addr_stb) begin
                    addr_d = addr_idx;
                    cnt_d  = CntLoad;
                    if (SPLIT_ENABLE) begin
                        split_ack_d = 1'b1;
                        state_d     = StRdSplitWait;
                    end else begin
                        state_d = StRdWait;
                    end
                end
            end

            // A repeated strobe of the kind already held simply overwrites it.
            StWrWaitData: begin
                if (target_rw) begin
                    if (addr_stb) begin
                        addr_d = addr_idx;
                    end
                    if (data_stb) begin
                        wdata_d = target_data_in;
                        ack_d   = 1'b1;
                        state_d = StWrite;
                    end
                end
            end

            StWrWaitAddr: begin
                if (target_rw) begin
                    if (data_stb) begin
                        wdata_d = target_data_in;
                    end
                    if (addr_stb) begin
                        addr_d  = addr_idx;
                        ack_d   = 1'b1;
                        state_d = StWrite;
                    end
                end
            end

            // Ack is already visible this cycle; the array update lands at its end.
            StWrite: begin
                mem_we  = 1'b1;
                state_d = StIdle;
            end

            StRdWait: begin
                if (cnt_q == 4'd0) begin
                    dout_d   = mem_rdata;
                    dvalid_d = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            // The request is registered on the edge where the counter reaches
            // zero, so it is visible READ_LATENCY cycles after the strobe.
            StRdSplitWait: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d       = 4'd0;
                    split_req_d = 1'b1;
                    state_d     = StRdSplitReq;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            // The target is busy while waiting, so memory cannot change before
            // the grant; sampling it here returns the latest prior write.
            StRdSplitReq: begin
                if (target_split_grant) begin
                    split_req_d = 1'b0;
                    dout_d      = mem_rdata;
                    dvalid_d    = 1'b1;
                    ack_d       = 1'b1;
                    state_d     = StIdle;
                end
            end

            default: begin
                split_req_d = 1'b0;
                state_d     = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            ack_q       <= 1'b0;
            split_ack_q <= 1'b0;
            split_req_q <= 1'b0;
            dvalid_q    <= 1'b0;
            dout_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            split_ack_q <= split_ack_d;
            split_req_q <= split_req_d;
            dvalid_q    <= dvalid_d;
            dout_q      <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign target_ready          = ready_q;
    assign target_ack            = ack_q;
    assign target_split_ack      = split_ack_q;
    assign target_split_req      = split_req_q;
    assign target_data_out       = dout_q;
    assign target_data_out_valid = dvalid_q;

endmodule

// File: tb/tb_split_target.sv
// Bench for split_target: one split-mode and one bus-holding instance, driven
// one transaction at a time. Expected bus events are queued when stimulus is
// issued and a negedge monitor pops and compares them as the DUTs produce them.
module tb_split_target;

    localparam int Lat   = 4;
    localparam int EvWr  = 0;
    localparam int EvRd  = 1;
    localparam int EvSa  = 2;
    localparam int EvRq  = 3;
    localparam int EvBad = 4;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_in [2];
    logic        addr_v  [2];
    logic [7:0]  data_in [2];
    logic        data_v  [2];
    logic        rw      [2];
    logic        grant   [2];
    logic        ready   [2];
    logic        ack     [2];
    logic        sack    [2];
    logic        sreq    [2];
    logic        dval    [2];
    logic [7:0]  dout    [2];
    logic        req_prev [2];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    ev_t         q0 [$];
    ev_t         q1 [$];
    logic [7:0]  mem_m [2][256];
    logic [7:0]  pool [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 splits every read; instance 1 holds the bus.
    split_target #(.MEM_ADDR_WIDTH(8), .READ_LATENCY(Lat), .SPLIT_ENABLE(1'b1)) u_split (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in[0]), .target_addr_in_valid(addr_v[0]),
        .target_data_in(data_in[0]), .target_data_in_valid(data_v[0]),
        .target_rw(rw[0]), .target_split_grant(grant[0]),
        .target_ready(ready[0]), .target_ack(ack[0]),
        .target_split_ack(sack[0]), .target_split_req(sreq[0]),
        .target_data_out(dout[0]), .target_data_out_valid(dval[0])
    );

    split_target #(.MEM_ADDR_WIDTH(8), .READ_LATENCY(Lat), .SPLIT_ENABLE(1'b0)) u_hold (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in[1]), .target_addr_in_valid(addr_v[1]),
        .target_data_in(data_in[1]), .target_data_in_valid(data_v[1]),
        .target_rw(rw[1]), .target_split_grant(grant[1]),
        .target_ready(ready[1]), .target_ack(ack[1]),
        .target_split_ack(sack[1]), .target_split_req(sreq[1]),
        .target_data_out(dout[1]), .target_data_out_valid(dval[1])
    );

    task automatic check_eq(input string name, input int d, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d: got %0h, want %0h", name, d, cyc, got, exp);
    endtask

    task automatic push(input int d, input int k, input int c, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = v;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic observe(input int d, input int k, input logic [7:0] v);
        ev_t e;
        bit  ok;
        n_checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            $display("FAIL unexpected_event dut%0d: got kind=%0d cyc=%0d data=%02h, want none",
                     d, k, cyc, v);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        ok = (e.kind == k) && (e.cyc == cyc) && (k != EvRd || e.data == v);
        if (ok) n_pass++;
        else $display("FAIL event dut%0d: got kind=%0d cyc=%0d data=%02h, want kind=%0d cyc=%0d data=%02h",
                      d, k, cyc, v, e.kind, e.cyc, e.data);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                if (sack[d]) observe(d, EvSa, 8'h00);
                if (sreq[d] && !req_prev[d]) observe(d, EvRq, 8'h00);
                if (ack[d] && dval[d]) observe(d, EvRd, dout[d]);
                else if (ack[d]) observe(d, EvWr, 8'h00);
                else if (dval[d]) observe(d, EvBad, dout[d]);
            end
            req_prev[d] <= sreq[d];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns the edge number that samples the strobes.
    task automatic drive(input int d, input logic av, input logic dv, input logic r,
                         input logic [15:0] a, input logic [7:0] v, output int s);
        addr_v[d]  = av;
        data_v[d]  = dv;
        rw[d]      = r;
        addr_in[d] = a;
        data_in[d] = v;
        s          = cyc + 1;
    endtask

    task automatic release_in(input int d);
        @(negedge clk);
        addr_v[d] = 1'b0;
        data_v[d] = 1'b0;
    endtask

    // mode 0: both strobes together; 1: address first; 2: data first.
    task automatic do_write(input int d, input logic [15:0] a, input logic [7:0] v,
                            input int mode, input int gap, input bit rep);
        int s;
        check_eq("ready_before_write", d, 32'(ready[d]), 32'd1);
        if (mode == 0) begin
            drive(d, 1'b1, 1'b1, 1'b1, a, v, s);
        end else begin
            if (mode == 1) drive(d, 1'b1, 1'b0, 1'b1, rep ? (a ^ 16'h0001) : a, 8'h00, s);
            else drive(d, 1'b0, 1'b1, 1'b1, 16'h0000, rep ? ~v : v, s);
            release_in(d);
            check_eq("ready_wait_second_beat", d, 32'(ready[d]), 32'd0);
            idle(gap);
            if (rep) begin
                if (mode == 1) drive(d, 1'b1, 1'b0, 1'b1, a, 8'h00, s);
                else drive(d, 1'b0, 1'b1, 1'b1, 16'h0000, v, s);
                release_in(d);
                idle(gap);
            end
            if (mode == 1) drive(d, 1'b0, 1'b1, 1'b1, 16'h0000, v, s);
            else drive(d, 1'b1, 1'b0, 1'b1, a, 8'h00, s);
        end
        push(d, EvWr, s, 8'h00);
        mem_m[d][a[7:0]] = v;
        release_in(d);
        check_eq("ready_in_write", d, 32'(ready[d]), 32'd0);
        idle(1);
        check_eq("ready_after_write", d, 32'(ready[d]), 32'd1);
    endtask

    task automatic do_read(input int d, input logic [15:0] a, input int gl, input bit inj,
                           input bit rst_mid);
        int         s;
        int         g;
        logic [7:0] e;
        e = mem_m[d][a[7:0]];
        check_eq("ready_before_read", d, 32'(ready[d]), 32'd1);
        drive(d, 1'b1, 1'b0, 1'b0, a, 8'hEE, s);
        if (d == 0) begin
            push(0, EvSa, s, 8'h00);
            push(0, EvRq, s + Lat - 1, 8'h00);
        end else begin
            push(1, EvRd, s + Lat, e);
        end
        release_in(d);
        check_eq("ready_in_read", d, 32'(ready[d]), 32'd0);
        if (inj) begin
            // A write while busy must leave no trace.
            drive(d, 1'b1, 1'b1, 1'b1, 16'h0099, 8'h11, g);
            release_in(d);
        end
        if (d == 1) begin
            wait_until(s + Lat);
            idle(1);
            check_eq("data_out_hold", d, 32'(dout[d]), 32'(e));
            check_eq("valid_drop", d, 32'(dval[d]), 32'd0);
        end else begin
            wait_until(s + Lat - 1);
            check_eq("split_req_high", d, 32'(sreq[d]), 32'd1);
            idle(gl);
            if (rst_mid) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_split_req", d, 32'(sreq[d]), 32'd0);
                check_eq("rst_ready", d, 32'(ready[d]), 32'd1);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                check_eq("split_req_held", d, 32'(sreq[d]), 32'd1);
                grant[d] = 1'b1;
                g = cyc + 1;
                push(0, EvRd, g, e);
                @(negedge clk);
                grant[d] = 1'b0;
                check_eq("split_req_dropped", d, 32'(sreq[d]), 32'd0);
            end
        end
    endtask

    initial begin
        logic [15:0] ra;
        int          op;
        pool = '{8'h12, 8'h34, 8'h56, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h3C};
        for (int d = 0; d < 2; d++) begin
            addr_in[d] = 16'h0000; addr_v[d] = 1'b0; data_in[d] = 8'h00;
            data_v[d] = 1'b0; rw[d] = 1'b0; grant[d] = 1'b0; req_prev[d] = 1'b0;
            for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ready", d, 32'(ready[d]), 32'd1);
            check_eq("reset_ack", d, 32'(ack[d]), 32'd0);
            check_eq("reset_split_ack", d, 32'(sack[d]), 32'd0);
            check_eq("reset_split_req", d, 32'(sreq[d]), 32'd0);
            check_eq("reset_valid", d, 32'(dval[d]), 32'd0);
            check_eq("reset_data_out", d, 32'(dout[d]), 32'd0);
        end
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            do_write(d, 16'h0012, 8'hAA, 0, 0, 1'b0);
            do_write(d, 16'h0034, 8'h5C, 2, 3, 1'b0);
        end
        do_read(1, 16'h0012, 0, 1'b0, 1'b0);
        do_read(1, 16'h0034, 0, 1'b0, 1'b0);
        do_read(0, 16'h0012, 6, 1'b0, 1'b0);
        do_read(0, 16'h0034, 0, 1'b1, 1'b0);
        do_read(1, 16'h0056, 0, 1'b1, 1'b0);
        do_read(0, 16'h0099, 0, 1'b0, 1'b0);
        do_read(1, 16'h0099, 0, 1'b0, 1'b0);
        do_write(0, 16'h1256, 8'h77, 2, 1, 1'b1);
        do_write(1, 16'h9A3C, 8'h3D, 1, 2, 1'b1);
        do_read(0, 16'hAB56, 2, 1'b0, 1'b0);
        do_read(1, 16'h003C, 0, 1'b0, 1'b0);
        do_read(0, 16'h0012, 3, 1'b0, 1'b1);
        do_read(0, 16'h0012, 1, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            for (int d = 0; d < 2; d++) begin
                ra = {8'($urandom_range(0, 255)), pool[$urandom_range(0, 7)]};
                op = int'($urandom_range(0, 4));
                if (op < 3) do_write(d, ra, 8'($urandom_range(0, 255)), op,
                                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                else do_read(d, ra, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        do_read(0, 16'h0099, 0, 1'b0, 1'b0);
        do_read(1, 16'h0099, 0, 1'b0, 1'b0);

        idle(8);
        check_eq("leftover_events", 0, 32'(q0.size()), 32'd0);
        check_eq("leftover_events", 1, 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
